frame_buf_arb: RTL and testbench
================================

FRAME_BUF_ARB -- requirements
Module: frame_buf_arb

Interface
REQ-001 SHALL have parameter P_AW, default 17: frame-buffer address width.
REQ-002 SHALL have parameter P_DW, default 16: pixel data width.
REQ-003 SHALL have ports:
  iClk  in  1  sole clock, rising edge.
  wRst  in  1  asynchronous, active-high reset.
  wEnClk  in  1  clock enable; all registers update only when high.
  wReqCam/wReqCnn/wReqLcd  in  1 each  burst request; cam=write, cnn/lcd=read.
  wAddrCam/wAddrCnn/wAddrLcd  in  P_AW each  burst base address.
  wLenCam/wLenCnn/wLenLcd  in  3 each  burst length minus 1 (1..8 beats).
  wWdataCam  in  P_DW  camera write data, consumed on each wAckCam beat.
  wGntCam/wGntCnn/wGntLcd  out  1 each  high for the whole owned burst.
  wAckCam/wAckCnn/wAckLcd  out  1 each  one pulse per beat issued.
  oMemCs/oMemWe  out  1 each  single-port memory select / write enable.
  oMemAddr  out  P_AW  memory address.
  oMemWdata  out  P_DW  memory write data.
  iMemRdata  in  P_DW  memory read data, valid 1 enabled cycle after read beat.
  oRdData  out  P_DW  returned read data.
  oRdVldCnn/oRdVldLcd  out  1 each  oRdData valid for that reader.
  rA_CurState  out  2  current FSM state, for debug.

Function
REQ-004 SHALL implement states p_Idle=0, p_Arb=1, p_Burst=2, p_Drain=3.
REQ-005 p_Idle -> p_Arb SHALL occur when any request is high.
REQ-006 In p_Arb the block SHALL latch the winner, its address and its length, and go to p_Burst.
REQ-007 Priority SHALL be: Cam absolute highest; Cnn and Lcd round-robin, with the pointer toggling after each read-burst grant.
REQ-008 After reset, the round-robin pointer SHALL favour Cnn.
REQ-009 In p_Burst, oMemCs and the winner's wAck SHALL be high for exactly len+1 consecutive enabled cycles.
REQ-010 Beat addresses SHALL be base, base+1, ..., modulo 2^P_AW, so wrap from all-ones to 0 is legal.
REQ-011 Cam bursts SHALL drive oMemWe=1 and oMemWdata=wWdataCam combinationally during each beat.
REQ-012 Read bursts SHALL drive oMemWe=0 and oMemWdata=0.
REQ-013 Requests SHALL NOT pre-empt a burst in progress; wGnt of the winner SHALL stay high from p_Burst entry to the last beat.
REQ-014 After the last beat: Cam -> p_Idle; read -> p_Drain for one enabled cycle to return the final datum, then p_Idle.
REQ-015 oRdData SHALL equal iMemRdata registered, with the reader's oRdVld high one enabled cycle after each read beat: latency 1, count len+1.
REQ-016 A request dropped during p_Arb/p_Burst SHALL NOT abort the burst; it completes at its latched length.
REQ-017 Address/length inputs SHALL be sampled only in p_Arb; changes during a burst are ignored.
REQ-018 When wEnClk=0, all state, counters and outputs SHALL hold.
REQ-019 Unused state encodings SHALL return to p_Idle.

Reset
REQ-020 wRst=1 SHALL asynchronously force: state p_Idle, all wGnt/wAck/oRdVld/oMemCs/oMemWe=0, oMemAddr=0, oRdData=0, beat counter=0, RR pointer=Cnn.
REQ-021 Reset mid-burst SHALL abandon the burst with no further memory access; no drain occurs.

Structure
REQ-022 State encodings, requester IDs (Cam=0, Cnn=1, Lcd=2) and the maximum burst length 8 SHALL be defined in a shared package, fbuf_pkg.
REQ-023 Priority/round-robin selection SHALL be one sub-module, fbuf_rr_sel (combinational, plus the pointer register).

Verification
REQ-024 Cam only, addr 0x00010, len 3 -> 4 writes at 0x10..0x13, wAckCam x4, return to p_Idle; total 6 enabled cycles from request.
REQ-025 Cnn and Lcd requesting simultaneously and continuously, len 0 -> grants alternate Cnn, Lcd, Cnn, Lcd; each oRdVld exactly 1 cycle after its beat.
REQ-026 Cam raised during a Cnn len-7 burst -> Cnn completes all 8 beats and drains; Cam is granted next, ahead of waiting Lcd.
REQ-027 Lcd read at addr 0x1FFFE, len 3 -> addresses 0x1FFFE, 0x1FFFF, 0x00000, 0x00001.
REQ-028 wRst pulsed on the 2nd beat of a len-5 write -> oMemCs=0 immediately, state p_Idle, no further beats after release.
REQ-029 wEnClk toggled 1/0 during a len-2 read -> 3 beats and 3 oRdVld pulses, all outputs frozen on disabled cycles.

Source files
------------

// File: rtl/fbuf_pkg.sv
// Shared definitions for the frame-buffer arbiter: FSM states, requester IDs
// and burst sizing.
package fbuf_pkg;

    typedef enum logic [1:0] {
        p_Idle  = 2'd0,
        p_Arb   = 2'd1,
        p_Burst = 2'd2,
        p_Drain = 2'd3
    } fbuf_state_e;

    localparam logic [1:0] ID_CAM = 2'd0;
    localparam logic [1:0] ID_CNN = 2'd1;
    localparam logic [1:0] ID_LCD = 2'd2;

    localparam int MAX_BURST = 8;
    localparam int LEN_W     = $clog2(MAX_BURST);

    function automatic logic isReadId(input logic [1:0] id);
        return (id == ID_CNN) || (id == ID_LCD);
    endfunction

endpackage

// File: rtl/fbuf_rr_sel.sv
// Requester selection: camera always wins, CNN and LCD share the remaining
// bandwidth through a round-robin pointer that flips on every read grant.
module fbuf_rr_sel
    import fbuf_pkg::*;
(
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_En,
    input  logic [2:0] i_Req,
    input  logic       i_Latch,
    output logic [1:0] o_Winner,
    output logic       o_Valid
);

    logic r_RrPtr;

    // r_RrPtr = 0 favours CNN, 1 favours LCD when both readers contend.
    always_comb begin
        o_Winner = ID_CAM;
        o_Valid  = |i_Req;
        if (i_Req[ID_CAM]) begin
            o_Winner = ID_CAM;
        end else if (i_Req[ID_CNN] && i_Req[ID_LCD]) begin
            o_Winner = r_RrPtr ? ID_LCD : ID_CNN;
        end else if (i_Req[ID_CNN]) begin
            o_Winner = ID_CNN;
        end else if (i_Req[ID_LCD]) begin
            o_Winner = ID_LCD;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_RrPtr <= 1'b0;
        end else if (i_En && i_Latch && o_Valid && isReadId(o_Winner)) begin
            r_RrPtr <= ~r_RrPtr;
        end
    end

endmodule

// File: rtl/frame_buf_arb.sv
// Single-port frame-buffer arbiter: one camera writer and two readers (CNN, LCD)
// share the memory in non-preemptible bursts of 1..8 beats.
module frame_buf_arb
    import fbuf_pkg::*;
#(
    parameter int P_AW = 17,
    parameter int P_DW = 16
) (
    input  logic              iClk,
    input  logic              wRst,
    input  logic              wEnClk,
    input  logic              wReqCam,
    input  logic              wReqCnn,
    input  logic              wReqLcd,
    input  logic [P_AW-1:0]   wAddrCam,
    input  logic [P_AW-1:0]   wAddrCnn,
    input  logic [P_AW-1:0]   wAddrLcd,
    input  logic [LEN_W-1:0]  wLenCam,
    input  logic [LEN_W-1:0]  wLenCnn,
    input  logic [LEN_W-1:0]  wLenLcd,
    input  logic [P_DW-1:0]   wWdataCam,
    output logic              wGntCam,
    output logic              wGntCnn,
    output logic              wGntLcd,
    output logic              wAckCam,
    output logic              wAckCnn,
    output logic              wAckLcd,
    output logic              oMemCs,
    output logic              oMemWe,
    output logic [P_AW-1:0]   oMemAddr,
    output logic [P_DW-1:0]   oMemWdata,
    input  logic [P_DW-1:0]   iMemRdata,
    output logic [P_DW-1:0]   oRdData,
    output logic              oRdVldCnn,
    output logic              oRdVldLcd,
    output logic [1:0]        rA_CurState
);

    fbuf_state_e       r_State;
    fbuf_state_e       w_NextState;
    logic [2:0]        r_ReqSnap;
    logic [1:0]        r_Winner;
    logic [P_AW-1:0]   r_Addr;
    logic [LEN_W-1:0]  r_Remain;
    logic              r_RdVldCnn;
    logic              r_RdVldLcd;

    logic [1:0]        w_SelWinner;
    logic              w_SelValid;
    logic              w_Beat;
    logic [P_AW-1:0]   w_LatchAddr;
    logic [LEN_W-1:0]  w_LatchLen;

    // Arbitration works on the request snapshot taken when leaving p_Idle, so a
    // request that drops during p_Arb still gets its burst.
    fbuf_rr_sel u_sel (
        .i_Clk    (iClk),
        .i_Rst    (wRst),
        .i_En     (wEnClk),
        .i_Req    (r_ReqSnap),
        .i_Latch  (r_State == p_Arb),
        .o_Winner (w_SelWinner),
        .o_Valid  (w_SelValid)
    );

    always_comb begin
        w_LatchAddr = wAddrCam;
        w_LatchLen  = wLenCam;
        case (w_SelWinner)
            ID_CNN: begin
                w_LatchAddr = wAddrCnn;
                w_LatchLen  = wLenCnn;
            end
            ID_LCD: begin
                w_LatchAddr = wAddrLcd;
                w_LatchLen  = wLenLcd;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_NextState = r_State;
        case (r_State)
            p_Idle:  if (wReqCam || wReqCnn || wReqLcd) w_NextState = p_Arb;
            p_Arb:   w_NextState = w_SelValid ? p_Burst : p_Idle;
            p_Burst: begin
                if (r_Remain == '0) begin
                    w_NextState = isReadId(r_Winner) ? p_Drain : p_Idle;
                end
            end
            p_Drain: w_NextState = p_Idle;
            default: w_NextState = p_Idle;
        endcase
    end

    always_ff @(posedge iClk or posedge wRst) begin
        if (wRst) begin
            r_State    <= p_Idle;
            r_ReqSnap  <= '0;
            r_Winner   <= ID_CAM;
            r_Addr     <= '0;
            r_Remain   <= '0;
            r_RdVldCnn <= 1'b0;
            r_RdVldLcd <= 1'b0;
        end else if (wEnClk) begin
            r_State <= w_NextState;
            if (r_State == p_Idle) begin
                r_ReqSnap <= {wReqLcd, wReqCnn, wReqCam};
            end
            if (r_State == p_Arb) begin
                r_Winner <= w_SelWinner;
                r_Addr   <= w_LatchAddr;
                r_Remain <= w_LatchLen;
            end
            if (w_Beat) begin
                r_Addr <= r_Addr + 1'b1;
                if (r_Remain != '0) begin
                    r_Remain <= r_Remain - 1'b1;
                end
            end
            // Read data arrives one enabled cycle after its beat.
            r_RdVldCnn <= w_Beat && (r_Winner == ID_CNN);
            r_RdVldLcd <= w_Beat && (r_Winner == ID_LCD);
        end
    end

    assign w_Beat      = (r_State == p_Burst);
    assign wGntCam     = w_Beat && (r_Winner == ID_CAM);
    assign wGntCnn     = w_Beat && (r_Winner == ID_CNN);
    assign wGntLcd     = w_Beat && (r_Winner == ID_LCD);
    assign wAckCam     = wGntCam;
    assign wAckCnn     = wGntCnn;
    assign wAckLcd     = wGntLcd;
    assign oMemCs      = w_Beat;
    assign oMemWe      = wGntCam;
    assign oMemAddr    = w_Beat ? r_Addr : '0;
    assign oMemWdata   = wGntCam ? wWdataCam : '0;
    assign oRdVldCnn   = r_RdVldCnn;
    assign oRdVldLcd   = r_RdVldLcd;
    assign oRdData     = (r_RdVldCnn || r_RdVldLcd) ? iMemRdata : '0;
    assign rA_CurState = r_State;

endmodule

// File: tb/tb_frame_buf_arb.sv
// Directed bench for frame_buf_arb with a one-cycle-latency memory model whose
// read data is a fixed function of the address.
module tb_frame_buf_arb;

    logic        iClk = 1'b0;
    logic        wRst;
    logic        wEnClk;
    logic        wReqCam, wReqCnn, wReqLcd;
    logic [16:0] wAddrCam, wAddrCnn, wAddrLcd;
    logic [2:0]  wLenCam, wLenCnn, wLenLcd;
    logic [15:0] wWdataCam;
    logic        wGntCam, wGntCnn, wGntLcd;
    logic        wAckCam, wAckCnn, wAckLcd;
    logic        oMemCs, oMemWe;
    logic [16:0] oMemAddr;
    logic [15:0] oMemWdata;
    logic [15:0] iMemRdata;
    logic [15:0] oRdData;
    logic        oRdVldCnn, oRdVldLcd;
    logic [1:0]  rA_CurState;

    int nPass   = 0;
    int nChecks = 0;
    logic [16:0] wrapAddr [4] = '{17'h1FFFE, 17'h1FFFF, 17'h00000, 17'h00001};

    frame_buf_arb #(.P_AW(17), .P_DW(16)) dut (
        .iClk(iClk), .wRst(wRst), .wEnClk(wEnClk),
        .wReqCam(wReqCam), .wReqCnn(wReqCnn), .wReqLcd(wReqLcd),
        .wAddrCam(wAddrCam), .wAddrCnn(wAddrCnn), .wAddrLcd(wAddrLcd),
        .wLenCam(wLenCam), .wLenCnn(wLenCnn), .wLenLcd(wLenLcd),
        .wWdataCam(wWdataCam),
        .wGntCam(wGntCam), .wGntCnn(wGntCnn), .wGntLcd(wGntLcd),
        .wAckCam(wAckCam), .wAckCnn(wAckCnn), .wAckLcd(wAckLcd),
        .oMemCs(oMemCs), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
        .oMemWdata(oMemWdata), .iMemRdata(iMemRdata), .oRdData(oRdData),
        .oRdVldCnn(oRdVldCnn), .oRdVldLcd(oRdVldLcd), .rA_CurState(rA_CurState)
    );

    always #5 iClk = ~iClk;

    function automatic logic [15:0] memFn(input logic [16:0] a);
        return a[15:0] ^ 16'hC3C3;
    endfunction

    // Synchronous read port: data for a read beat appears in the next enabled cycle.
    always @(posedge iClk or posedge wRst) begin
        if (wRst) begin
            iMemRdata <= '0;
        end else if (wEnClk && oMemCs && !oMemWe) begin
            iMemRdata <= memFn(oMemAddr);
        end
    end

    task automatic nextCycle();
        @(negedge iClk);
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic checkOutput(input string tag, input logic [1:0] st, input logic cs,
                               input logic we, input logic [16:0] addr, input logic [2:0] gnt,
                               input logic [1:0] vld, input logic [15:0] rd,
                               input logic [15:0] wd);
        cmp({tag, ".state"}, 32'(rA_CurState), 32'(st));
        cmp({tag, ".cs"},    32'(oMemCs), 32'(cs));
        cmp({tag, ".we"},    32'(oMemWe), 32'(we));
        cmp({tag, ".addr"},  32'(oMemAddr), 32'(addr));
        cmp({tag, ".gnt"},   32'({wGntLcd, wGntCnn, wGntCam}), 32'(gnt));
        cmp({tag, ".ack"},   32'({wAckLcd, wAckCnn, wAckCam}), 32'(gnt));
        cmp({tag, ".vld"},   32'({oRdVldLcd, oRdVldCnn}), 32'(vld));
        cmp({tag, ".rd"},    32'(oRdData), 32'(rd));
        cmp({tag, ".wd"},    32'(oMemWdata), 32'(wd));
    endtask

    // One len-0 read grant from p_Idle through p_Drain and back to p_Idle.
    task automatic readGrant(input string tag, input logic isLcd, input logic [16:0] addr);
        nextCycle();
        checkOutput({tag, "Arb"}, 2'd1, 0, 0, 17'h0, 3'b000, 2'b00, 16'h0, 16'h0);
        nextCycle();
        checkOutput({tag, "Beat"}, 2'd2, 1, 0, addr, isLcd ? 3'b100 : 3'b010,
                    2'b00, 16'h0, 16'h0);
        nextCycle();
        checkOutput({tag, "Drain"}, 2'd3, 0, 0, 17'h0, 3'b000,
                    isLcd ? 2'b10 : 2'b01, memFn(addr), 16'h0);
        nextCycle();
        checkOutput({tag, "Idle"}, 2'd0, 0, 0, 17'h0, 3'b000, 2'b00, 16'h0, 16'h0);
    endtask

    initial begin
        wRst = 1'b1; wEnClk = 1'b1;
        wReqCam = 0; wReqCnn = 0; wReqLcd = 0;
        wAddrCam = '0; wAddrCnn = '0; wAddrLcd = '0;
        wLenCam = '0; wLenCnn = '0; wLenLcd = '0; wWdataCam = '0;
        repeat (2) nextCycle();
        checkOutput("reset", 2'd0, 0, 0, 17'h0, 3'b000, 2'b00, 16'h0, 16'h0);
        wRst = 1'b0;

        // Camera len-3 write at 0x10; address input changes mid-burst are ignored.
        wReqCam = 1; wAddrCam = 17'h00010; wLenCam = 3'd3; wWdataCam = 16'h1000;
        nextCycle();
        checkOutput("camArb", 2'd1, 0, 0, 17'h0, 3'b000, 2'b00, 16'h0, 16'h0);
        wReqCam = 0;
        nextCycle();
        wAddrCam = 17'h00055; wLenCam = 3'd0;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("camBeat%0d", i), 2'd2, 1, 1, 17'(32'h10 + i),
                        3'b001, 2'b00, 16'h0, 16'(32'h1000 + i));
            wWdataCam = 16'(32'h1001 + i);
            nextCycle();
        end
        checkOutput("camIdle", 2'd0, 0, 0, 17'h0, 3'b000, 2'b00, 16'h0, 16'h0);

        // CNN and LCD contending continuously alternate, CNN first.
        wReqCnn = 1; wReqLcd = 1; wAddrCnn = 17'h00100; wAddrLcd = 17'h00200;
        wLenCnn = 3'd0; wLenLcd = 3'd0;
        readGrant("rr0Cnn", 1'b0, 17'h00100);
        readGrant("rr1Lcd", 1'b1, 17'h00200);
        readGrant("rr2Cnn", 1'b0, 17'h00100);
        readGrant("rr3Lcd", 1'b1, 17'h00200);
        wReqCnn = 0; wReqLcd = 0;

        // CNN len-7 burst is not pre-empted by a camera request; camera goes next.
        wReqCnn = 1; wAddrCnn = 17'h00300; wLenCnn = 3'd7;
        nextCycle();
        checkOutput("cnn8Arb", 2'd1, 0, 0, 17'h0, 3'b000, 2'b00, 16'h0, 16'h0);
        nextCycle();
        wReqCnn = 0; wReqCam = 1; wAddrCam = 17'h00040; wLenCam = 3'd0; wWdataCam = 16'hBEEF;
        wReqLcd = 1; wAddrLcd = 17'h00500; wLenLcd = 3'd0;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("cnn8Beat%0d", i), 2'd2, 1, 0, 17'(32'h300 + i), 3'b010,
                        (i == 0) ? 2'b00 : 2'b01,
                        (i == 0) ? 16'h0 : memFn(17'(32'h300 + i - 1)), 16'h0);
            nextCycle();
        end
        checkOutput("cnn8Drain", 2'd3, 0, 0, 17'h0, 3'b000, 2'b01, memFn(17'h00307), 16'h0);
        nextCycle();
        checkOutput("preemptIdle", 2'd0, 0, 0, 17'h0, 3'b000, 2'b00, 16'h0, 16'h0);
        nextCycle();
        nextCycle();
        checkOutput("preemptCam", 2'd2, 1, 1, 17'h00040, 3'b001, 2'b00, 16'h0, 16'hBEEF);
        wReqCam = 0; wReqLcd = 0;
        nextCycle();
        checkOutput("preemptDone", 2'd0, 0, 0, 17'h0, 3'b000, 2'b00, 16'h0, 16'h0);

        // LCD len-3 read wrapping past the top of the address space.
        wReqLcd = 1; wAddrLcd = 17'h1FFFE; wLenLcd = 3'd3;
        nextCycle();
        wReqLcd = 0;
        nextCycle();
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("wrapBeat%0d", i), 2'd2, 1, 0, wrapAddr[i], 3'b100,
                        (i == 0) ? 2'b00 : 2'b10,
                        (i == 0) ? 16'h0 : memFn(wrapAddr[(i + 3) % 4]), 16'h0);
            nextCycle();
        end
        checkOutput("wrapDrain", 2'd3, 0, 0, 17'h0, 3'b000, 2'b10, memFn(17'h00001), 16'h0);
        nextCycle();

        // CNN len-2 read with the clock enable toggling: disabled cycles freeze outputs.
        wReqCnn = 1; wAddrCnn = 17'h00600; wLenCnn = 3'd2;
        nextCycle();
        wReqCnn = 0;
        nextCycle();
        for (int k = 0; k < 4; k++) begin
            for (int f = 0; f < 2; f++) begin
                checkOutput($sformatf("enStep%0d_%0d", k, f), (k < 3) ? 2'd2 : 2'd3,
                            k < 3, 0, (k < 3) ? 17'(32'h600 + k) : 17'h0,
                            (k < 3) ? 3'b010 : 3'b000, (k == 0) ? 2'b00 : 2'b01,
                            (k == 0) ? 16'h0 : memFn(17'(32'h600 + k - 1)), 16'h0);
                wEnClk = (f == 0) ? 1'b0 : 1'b1;
                nextCycle();
            end
        end
        checkOutput("enIdle", 2'd0, 0, 0, 17'h0, 3'b000, 2'b00, 16'h0, 16'h0);

        // Reset on the second beat of a camera len-5 write abandons the burst.
        wReqCam = 1; wAddrCam = 17'h00080; wLenCam = 3'd5; wWdataCam = 16'h2222;
        nextCycle();
        wReqCam = 0;
        nextCycle();
        checkOutput("rstBeat0", 2'd2, 1, 1, 17'h00080, 3'b001, 2'b00, 16'h0, 16'h2222);
        nextCycle();
        checkOutput("rstBeat1", 2'd2, 1, 1, 17'h00081, 3'b001, 2'b00, 16'h0, 16'h2222);
        wRst = 1'b1;
        #1;
        checkOutput("rstAsync", 2'd0, 0, 0, 17'h0, 3'b000, 2'b00, 16'h0, 16'h0);
        nextCycle();
        wRst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checkOutput($sformatf("rstAfter%0d", i), 2'd0, 0, 0, 17'h0, 3'b000, 2'b00,
                        16'h0, 16'h0);
        end

        // Reset put the round-robin pointer back on CNN (it favoured LCD before).
        wReqCnn = 1; wReqLcd = 1; wAddrCnn = 17'h00700; wAddrLcd = 17'h00710;
        wLenCnn = 3'd0; wLenLcd = 3'd0;
        readGrant("ptrCnn", 1'b0, 17'h00700);
        readGrant("ptrLcd", 1'b1, 17'h00710);
        wReqCnn = 0; wReqLcd = 0;

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
